// File: rtl/alu_hilo_seq.sv
// alu_hilo_seq: iterative HI/LO multiply / multiply-accumulate / divide unit.
// Define ALU_HILO_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete as no-ops.
module alu_hilo_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, divzero_q, divzero_d;
`ifdef ALU_HILO_DIV_EN
  logic               rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH:0]   p_div;
  logic [WIDTH-1:0]   quo, rem;
`endif

  logic               accept, last, run_op, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   p_mul, p_step;
  logic [2*WIDTH-1:0] prod, sprod;

  assign accept    = (state_q == IDLE) && Start;
  assign last      = (state_q == RUN) && (cnt_q == '0);
  assign is_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
  assign a_neg     = is_signed & A[WIDTH-1];
  assign b_neg     = is_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? (~A + 1'b1) : A;
  assign b_mag     = b_neg ? (~B + 1'b1) : B;
`ifdef ALU_HILO_DIV_EN
  assign run_op    = (Op != OP_MTHI) && (Op != OP_MTLO);
`else
  assign run_op    = !Op[2];
`endif

  // Shift-add multiply: upper half accumulates, multiplier bits retire from the bottom
  assign mul_sum = p_q[2*WIDTH:WIDTH] + {1'b0, b_q};
  assign p_mul   = p_q[0] ? {1'b0, mul_sum, p_q[WIDTH-1:1]} : {1'b0, p_q[2*WIDTH:1]};

`ifdef ALU_HILO_DIV_EN
  // Restoring divide: remainder in the upper half, quotient bits shift in at the bottom
  assign div_trial = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
  assign p_div     = div_trial[WIDTH] ? {p_q[2*WIDTH-1:0], 1'b0}
                                      : {div_trial, p_q[WIDTH-2:0], 1'b1};
  assign p_step    = op_q[2] ? p_div : p_mul;
`else
  assign p_step    = p_mul;
`endif

  assign prod  = p_step[2*WIDTH-1:0];
  assign sprod = neg_q ? (~prod + 1'b1) : prod;
`ifdef ALU_HILO_DIV_EN
  assign quo   = neg_q  ? (~prod[WIDTH-1:0] + 1'b1) : prod[WIDTH-1:0];
  assign rem   = rneg_q ? (~prod[2*WIDTH-1:WIDTH] + 1'b1) : prod[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      b_q       <= '0;
      p_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
`ifdef ALU_HILO_DIV_EN
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      b_q       <= b_d;
      p_q       <= p_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
`ifdef ALU_HILO_DIV_EN
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start && run_op) state_d = RUN;
      RUN:     if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    b_d       = b_q;
    p_d       = p_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
`ifdef ALU_HILO_DIV_EN
    rneg_d    = rneg_q;
    dz_d      = dz_q;
`endif
    if (accept) begin
      op_d  = Op;
      cnt_d = CW'(WIDTH - 1);
      neg_d = a_neg ^ b_neg;
      b_d   = b_mag;
      p_d   = {{(WIDTH+1){1'b0}}, a_mag};
`ifdef ALU_HILO_DIV_EN
      rneg_d = a_neg;
      dz_d   = Op[2] && (B == '0);
      // A zero divisor makes the divider register free, so it carries raw A for HI
      if (Op[2] && (B == '0)) b_d = A;
`endif
      case (Op)
        OP_MTHI: begin hi_d = A; done_d = 1'b1; end
        OP_MTLO: begin lo_d = A; done_d = 1'b1; end
`ifndef ALU_HILO_DIV_EN
        OP_DIV, OP_DIVU: done_d = 1'b1;
`endif
        default: ;
      endcase
    end else if (state_q == RUN) begin
      cnt_d = last ? '0 : cnt_q - 1'b1;
      p_d   = p_step;
      if (last) begin
        done_d = 1'b1;
        case (op_q)
          OP_MULT, OP_MULTU: {hi_d, lo_d} = sprod;
          OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + sprod;
          OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - sprod;
`ifdef ALU_HILO_DIV_EN
          default: begin
            if (dz_q) begin
              lo_d      = '1;
              hi_d      = b_q;
              divzero_d = 1'b1;
            end else begin
              lo_d = quo;
              hi_d = rem;
            end
          end
`else
          default: ;
`endif
        endcase
      end
    end
  end

  always_comb begin
    Busy    = (state_q == RUN);
    Done    = done_q;
    DivZero = divzero_q;
    HI      = hi_q;
    LO      = lo_q;
  end
endmodule

// File: tb/tb_alu_hilo_seq.sv
// tb_alu_hilo_seq: directed and random checks of alu_hilo_seq (WIDTH=32) against a 64-bit arithmetic model.
// Expected divide behaviour follows ALU_HILO_DIV_EN, matching the build of the design.
module tb_alu_hilo_seq;
  localparam int W = 32;

  logic          Clk, Rst, Start, Busy, Done, DivZero;
  logic [2:0]    Op;
  logic [W-1:0]  A, B, HI, LO;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;
  logic          m_dz = 1'b0;

  alu_hilo_seq #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: whole-register arithmetic on 64-bit values; returns expected RUN length
  task automatic model_apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        ua, ub, uq, ur, acc;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {m_hi, m_lo};
    m_dz = 1'b0;
    lat  = W;
    case (op)
      3'd0: acc = sa * sb;
      3'd1: acc = ua * ub;
      3'd2: acc = acc + sa * sb;
      3'd3: acc = acc - sa * sb;
      3'd4, 3'd5: begin
`ifdef ALU_HILO_DIV_EN
        if (b == '0) begin
          acc  = {a, 32'hFFFF_FFFF};
          m_dz = 1'b1;
        end else if (op == 3'd4) begin
          sq  = sa / sb;
          sr  = sa % sb;
          acc = {sr[31:0], sq[31:0]};
        end else begin
          uq  = ua / ub;
          ur  = ua % ub;
          acc = {ur[31:0], uq[31:0]};
        end
`else
        lat = 0;
`endif
      end
      3'd6: begin acc[63:32] = a; lat = 0; end
      default: begin acc[31:0] = a; lat = 0; end
    endcase
    m_hi = acc[63:32];
    m_lo = acc[31:0];
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    step();
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Issues one op, waits (bounded) for Done, checks latency and results; leaves the bench in the Done cycle
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit intrude);
    int lat;
    int n;
    model_apply(op, a, b, lat);
    applyStimulus(op, a, b);
    n = 0;
    while (Done !== 1'b1 && n < lat + 4) begin
      checkOutput({tag, " busy"}, {31'd0, Busy}, 32'd1);
      if (intrude) checkOutput({tag, " lo_not_9"}, {31'd0, LO !== 32'd9}, 32'd1);
      if (intrude && n == 3) begin
        Start = 1'b1;
        Op    = 3'd7;
        A     = 32'd9;
      end else if (intrude) begin
        Start = 1'b0;
      end
      step();
      n++;
    end
    Start = 1'b0;
    checkOutput({tag, " latency"}, n, lat);
    checkOutput({tag, " done"},    {31'd0, Done},    32'd1);
    checkOutput({tag, " busy_end"}, {31'd0, Busy},   32'd0);
    checkOutput({tag, " divzero"}, {31'd0, DivZero}, {31'd0, m_dz});
    checkOutput({tag, " hi"}, HI, m_hi);
    checkOutput({tag, " lo"}, LO, m_lo);
  endtask

  task automatic idle_check(input string tag);
    step();
    checkOutput({tag, " done_pulse"}, {31'd0, Done}, 32'd0);
    checkOutput({tag, " hi_hold"}, HI, m_hi);
    checkOutput({tag, " lo_hold"}, LO, m_lo);
  endtask

  initial begin
    logic [2:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic [2:0]   abort_op;
    Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    step();
    step();
    Rst = 1'b0;
    checkOutput("reset hi",   HI, 32'd0);
    checkOutput("reset lo",   LO, 32'd0);
    checkOutput("reset busy", {31'd0, Busy}, 32'd0);
    checkOutput("reset done", {31'd0, Done}, 32'd0);
    checkOutput("reset dz",   {31'd0, DivZero}, 32'd0);
    idle_check("idle");

    $display("[TB] multiply");
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    checkOutput("mult hi const", HI, 32'hFFFF_FFFF);
    checkOutput("mult lo const", LO, 32'hFFFF_FFFA);
    idle_check("mult");
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    checkOutput("multu hi const", HI, 32'h0000_0002);
    idle_check("multu");

    $display("[TB] accumulate");
    run_op("mthi", 3'd6, 32'd0, 32'd0, 1'b0);
    run_op("mtlo", 3'd7, 32'd10, 32'd0, 1'b0);
    run_op("madd", 3'd2, 32'd4, 32'd5, 1'b0);
    checkOutput("madd lo const", LO, 32'd30);
    run_op("msub", 3'd3, 32'd6, 32'd6, 1'b0);
    checkOutput("msub lo const", LO, 32'hFFFF_FFFA);
    idle_check("msub");

    $display("[TB] divide");
    run_op("div",      3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_z",   3'd5, 32'd7, 32'd0, 1'b0);
    idle_check("divu_z");
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_negb", 3'd4, 32'd100, 32'hFFFF_FFF9, 1'b0);

    $display("[TB] start while busy and back-to-back");
    run_op("mult_busy", 3'd0, 32'd3, 32'd3, 1'b1);
    run_op("mult_b2b",  3'd0, 32'd7, 32'hFFFF_FFFB, 1'b0);
    idle_check("mult_b2b");

    $display("[TB] random");
    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = '0;
        1:       r_b = '1;
        2:       r_b = 32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, 1'b0);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_check($sformatf("rand%0d gap", i));
    end

    $display("[TB] reset during run");
    run_op("pre_abort_hi", 3'd6, 32'h1234_5678, 32'd0, 1'b0);
`ifdef ALU_HILO_DIV_EN
    abort_op = 3'd4;
`else
    abort_op = 3'd0;
`endif
    applyStimulus(abort_op, 32'd1000, 32'd3);
    for (int c = 1; c < 10; c++) step();
    checkOutput("abort busy_before", {31'd0, Busy}, 32'd1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    checkOutput("abort busy", {31'd0, Busy}, 32'd0);
    checkOutput("abort done", {31'd0, Done}, 32'd0);
    checkOutput("abort hi", HI, 32'd0);
    checkOutput("abort lo", LO, 32'd0);
    for (int c = 0; c < W + 4; c++) begin
      step();
      checkOutput("abort no_done", {31'd0, Done}, 32'd0);
    end
    checkOutput("abort hi_after", HI, 32'd0);

    $display("[TB] divide after reset");
    run_op("post_hi",  3'd6, 32'h0000_1234, 32'd0, 1'b0);
    run_op("post_lo",  3'd7, 32'h0000_5678, 32'd0, 1'b0);
    run_op("post_div", 3'd4, 32'd5, 32'd0, 1'b0);
    idle_check("post_div");
    run_op("post_divu", 3'd5, 32'd50, 32'd7, 1'b0);
    idle_check("post_divu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_hilo_seq.md
ALU_HILO_SEQ -- requirements
Module: alu_hilo_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/HI/LO width (WIDTH >= 4, even).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Clk  in  1  rising-edge clock.
REQ-004 Rst  in  1  synchronous active-high reset.
REQ-005 Start  in  1  request; sampled on Clk rising edge.
REQ-006 Op  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 DIV, 101 DIVU, 110 MTHI, 111 MTLO.
REQ-007 A  in  WIDTH  operand A (multiplicand/dividend/MTHI-MTLO source).
REQ-008 B  in  WIDTH  operand B (multiplier/divisor).
REQ-009 Busy  out  1  high while an iterative operation runs.
REQ-010 Done  out  1  one-cycle pulse: HI/LO just updated.
REQ-011 DivZero  out  1  one-cycle pulse with Done when a divide had B==0.
REQ-012 HI  out  WIDTH  HI register; LO  out  WIDTH  LO register.

Function
REQ-013 The block SHALL implement states IDLE and RUN; Busy SHALL equal (state==RUN).
REQ-014 Start SHALL be accepted only in IDLE; Start while Busy SHALL be ignored with no side effect.
REQ-015 On accept of ops 000-101, the block SHALL latch Op, operand magnitudes and result sign, load a counter with WIDTH-1, and enter RUN.
REQ-016 RUN SHALL last exactly WIDTH cycles (one shift-add or restoring-subtract step per cycle); at the edge ending the final RUN cycle the block SHALL write HI/LO, return to IDLE, and assert Done for the following cycle.
REQ-017 Latency: Start sampled at edge t0 -> Busy high cycles t0+1..t0+WIDTH -> HI/LO valid and Done high at t0+WIDTH+1.
REQ-018 A Start in the Done cycle SHALL be accepted (back-to-back, no bubble).
REQ-019 MULT/MULTU SHALL write {HI,LO} = signed/unsigned 2*WIDTH-bit product of A and B.
REQ-020 MADD/MSUB SHALL write {HI,LO} = {HI,LO} +/- signed product, modulo 2^(2*WIDTH), using HI/LO values at completion.
REQ-021 DIV/DIVU SHALL write LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend's sign.
REQ-022 Signed DIV of most-negative by -1 SHALL give LO = most-negative, HI = 0.
REQ-023 Divide with B==0 SHALL take full latency, write LO = all ones, HI = A, and pulse DivZero with Done.
REQ-024 MTHI/MTLO SHALL write A into HI/LO at the accept edge, not assert Busy, and pulse Done the next cycle.
REQ-025 HI/LO SHALL change only at REQ-016/REQ-024 edges or reset.

Reset
REQ-026 Rst SHALL force state IDLE, counter 0, HI=0, LO=0, Busy=0, Done=0, DivZero=0; Rst SHALL take priority over Start.
REQ-027 Rst asserted mid-RUN SHALL abort the operation with no HI/LO write and no Done pulse.

Configuration
REQ-028 Macro ALU_HILO_DIV_EN SHALL, when defined, compile in the divider datapath and REQ-021..REQ-023 behaviour.
REQ-029 Without ALU_HILO_DIV_EN, DIV/DIVU SHALL be accepted as single-cycle no-ops: HI/LO unchanged, Busy stays 0, Done pulses next cycle, DivZero stays 0.

Verification (WIDTH=32)
REQ-030 Reset then idle: HI=0, LO=0, Busy=0, Done=0 on first cycle after Rst deassertion.
REQ-031 MULT A=0xFFFFFFFE (-2), B=3 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done one cycle; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 MTHI A=0, MTLO A=10, then MADD A=4, B=5 -> HI=0, LO=30; then MSUB A=6, B=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7, DivZero pulse with Done.
REQ-034 MULT A=3,B=3 with Start re-pulsed (Op=MTLO, A=9) during Busy -> ignored, LO=9 never seen; second MULT issued in Done cycle accepted back-to-back.
REQ-035 Rst asserted on cycle 10 of a DIV -> HI=LO=0, Busy=0, no Done; build without ALU_HILO_DIV_EN -> DIV leaves HI/LO unchanged, Done next cycle.
